// File: rtl/mm_arbiter.sv
// Two-port round-robin arbiter that serialises requests onto the mainmemory
// address-then-write / single-pulse-read protocol, with a read-valid watchdog.
module mm_arbiter #(
    parameter int RD_TIMEOUT = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req_valid,
    input  logic [1:0]   req_write,
    input  logic [31:0]  req0_addr,
    input  logic [31:0]  req1_addr,
    input  logic [31:0]  req0_be,
    input  logic [31:0]  req1_be,
    input  logic [255:0] req0_wdata,
    input  logic [255:0] req1_wdata,
    output logic [1:0]   req_ready,
    output logic [1:0]   rsp_done,
    output logic         rsp_err,
    output logic [255:0] rsp_rdata,
    output logic         busy,
    output logic [31:0]  mem_a,
    output logic [31:0]  mem_be,
    output logic [255:0] mem_wd,
    output logic         mem_write,
    output logic         mem_read,
    input  logic [255:0] mem_rd,
    input  logic         mem_valid
);

    localparam int CW = $clog2(RD_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_SETUP,
        S_WR_COMMIT,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_DONE
    } state_t;

    state_t         r_state;
    logic           r_lastGrant;
    logic           r_owner;
    logic [31:0]    r_addr;
    logic [31:0]    r_be;
    logic [255:0]   r_wdata;
    logic [CW-1:0]  r_cnt;

    logic           w_grant;
    logic           w_accept;

    // Contention goes to whichever requester was not served last.
    always_comb begin
        if (req_valid == 2'b11) begin
            w_grant = ~r_lastGrant;
        end else begin
            w_grant = ~req_valid[0];
        end
    end

    assign w_accept = (r_state == S_IDLE) && (req_valid != 2'b00);
    assign busy     = (r_state != S_IDLE);

    always_comb begin
        req_ready = 2'b00;
        if (w_accept) begin
            req_ready = w_grant ? 2'b10 : 2'b01;
        end
    end

    // Memory-side and response outputs are all registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_lastGrant <= 1'b1;
            r_owner     <= 1'b0;
            r_addr      <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            rsp_done    <= '0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
            mem_a       <= '0;
            mem_be      <= '0;
            mem_wd      <= '0;
            mem_write   <= 1'b0;
            mem_read    <= 1'b0;
        end else begin
            rsp_done <= '0;
            rsp_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_owner     <= w_grant;
                        r_lastGrant <= w_grant;
                        r_addr      <= w_grant ? req1_addr  : req0_addr;
                        r_be        <= w_grant ? req1_be    : req0_be;
                        r_wdata     <= w_grant ? req1_wdata : req0_wdata;
                        mem_a       <= w_grant ? req1_addr  : req0_addr;
                        if (req_write[w_grant]) begin
                            r_state <= S_WR_SETUP;
                        end else begin
                            mem_read <= 1'b1;
                            r_state  <= S_RD_ISSUE;
                        end
                    end
                end
                S_WR_SETUP: begin
                    mem_write <= 1'b1;
                    mem_be    <= r_be;
                    mem_wd    <= r_wdata;
                    r_state   <= S_WR_COMMIT;
                end
                S_WR_COMMIT: begin
                    mem_write <= 1'b0;
                    mem_be    <= '0;
                    mem_wd    <= '0;
                    rsp_done  <= r_owner ? 2'b10 : 2'b01;
                    r_state   <= S_DONE;
                end
                S_RD_ISSUE: begin
                    mem_read <= 1'b0;
                    r_cnt    <= '0;
                    r_state  <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (mem_valid) begin
                        rsp_rdata <= mem_rd;
                        rsp_done  <= r_owner ? 2'b10 : 2'b01;
                        r_state   <= S_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        rsp_done  <= r_owner ? 2'b10 : 2'b01;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_cnt   <= '0;
                    mem_a   <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mm_arbiter.sv
// Directed bench for mm_arbiter against a small behavioural mainmemory model
// (registered address for writes, read data valid two cycles after the pulse).
module tb_mm_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_write;
    logic [31:0]  req0_addr, req1_addr;
    logic [31:0]  req0_be, req1_be;
    logic [255:0] req0_wdata, req1_wdata;
    logic [1:0]   req_ready;
    logic [1:0]   rsp_done;
    logic         rsp_err;
    logic [255:0] rsp_rdata;
    logic         busy;
    logic [31:0]  mem_a;
    logic [31:0]  mem_be;
    logic [255:0] mem_wd;
    logic         mem_write;
    logic         mem_read;
    logic [255:0] mem_rd;
    logic         mem_valid;

    int vecCount = 0;
    int missCount = 0;
    logic prevRead;

    localparam logic [255:0] PAT_A5 = {32{8'hA5}};
    localparam logic [255:0] PAT_5A = {32{8'h5A}};
    localparam logic [255:0] PAT_FF = {32{8'hFF}};
    localparam logic [255:0] RAM0   = {8{32'hC0DE_0000}};
    localparam logic [255:0] RAM1   = {8{32'hBEEF_0001}};

    always #5 clk = ~clk;

    mm_arbiter #(.RD_TIMEOUT(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req0_addr  (req0_addr),
        .req1_addr  (req1_addr),
        .req0_be    (req0_be),
        .req1_be    (req1_be),
        .req0_wdata (req0_wdata),
        .req1_wdata (req1_wdata),
        .req_ready  (req_ready),
        .rsp_done   (rsp_done),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata),
        .busy       (busy),
        .mem_a      (mem_a),
        .mem_be     (mem_be),
        .mem_wd     (mem_wd),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_rd     (mem_rd),
        .mem_valid  (mem_valid)
    );

    // Memory model: address is registered every cycle, writes land at the
    // registered address; a read pulse returns data two cycles later.
    logic [255:0] ram [8] = '{RAM0, RAM1, '0, '0, '0, '0, '0, '0};
    logic [31:0]  mRegA = '0;
    logic [31:0]  mS1Addr = '0;
    logic         mS1 = 1'b0;
    logic         mS2 = 1'b0;
    logic [255:0] mRd = '0;
    logic         forceInvalid = 1'b0;

    always @(posedge clk) begin
        mRegA   <= mem_a;
        mS1     <= mem_read;
        mS1Addr <= mem_a;
        mS2     <= mS1;
        mRd     <= ram[mS1Addr[2:0]];
        if (mem_write) begin
            for (int b = 0; b < 32; b++) begin
                if (mem_be[b]) ram[mRegA[2:0]][b*8 +: 8] <= mem_wd[b*8 +: 8];
            end
        end
    end

    assign mem_rd    = mRd;
    assign mem_valid = mS2 & ~forceInvalid;

    task automatic applyStimulus(input logic [1:0] v, input logic [1:0] w,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] b0, input logic [31:0] b1,
                                 input logic [255:0] d0, input logic [255:0] d1);
        req_valid  = v;
        req_write  = w;
        req0_addr  = a0;
        req1_addr  = a1;
        req0_be    = b0;
        req1_be    = b1;
        req0_wdata = d0;
        req1_wdata = d1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] obs,
                               input logic [255:0] exp);
        vecCount++;
        assert (obs === exp) else begin
            missCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
        nextCycle();
        nextCycle();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", rsp_done, 0);
        checkOutput("rst_mem_a", mem_a, 0);
        checkOutput("rst_mem_wr", mem_write, 0);
        checkOutput("rst_mem_rd", mem_read, 0);
        checkOutput("rst_rdata", rsp_rdata, 0);
        checkOutput("rst_ready", req_ready, 0);
        rst_n = 1'b1;
        nextCycle();

        // 1: req0 write to line 3
        applyStimulus(2'b01, 2'b01, 32'd3, '0, 32'hFFFF_FFFF, '0, PAT_A5, '0);
        #1;
        checkOutput("t1_ready", req_ready, 2'b01);
        nextCycle();
        applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
        checkOutput("t1_c1_write", mem_write, 0);
        checkOutput("t1_c1_addr", mem_a, 3);
        checkOutput("t1_c1_busy", busy, 1);
        checkOutput("t1_c1_be", mem_be, 0);
        nextCycle();
        checkOutput("t1_c2_write", mem_write, 1);
        checkOutput("t1_c2_be", mem_be, 32'hFFFF_FFFF);
        checkOutput("t1_c2_wd", mem_wd, PAT_A5);
        checkOutput("t1_c2_done", rsp_done, 0);
        nextCycle();
        checkOutput("t1_c3_done", rsp_done, 2'b01);
        checkOutput("t1_c3_err", rsp_err, 0);
        checkOutput("t1_c3_write", mem_write, 0);
        checkOutput("t1_c3_wd", mem_wd, 0);
        checkOutput("t1_ram3", ram[3], PAT_A5);
        nextCycle();
        checkOutput("t1_idle_busy", busy, 0);
        checkOutput("t1_idle_addr", mem_a, 0);
        checkOutput("t1_idle_done", rsp_done, 0);

        // 2: req1 reads line 3 back
        applyStimulus(2'b10, 2'b00, '0, 32'd3, '0, '0, '0, '0);
        #1;
        checkOutput("t2_ready", req_ready, 2'b10);
        nextCycle();
        applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
        checkOutput("t2_c1_read", mem_read, 1);
        checkOutput("t2_c1_addr", mem_a, 3);
        nextCycle();
        checkOutput("t2_c2_read", mem_read, 0);
        nextCycle();
        checkOutput("t2_c3_done", rsp_done, 0);
        nextCycle();
        checkOutput("t2_c4_done", rsp_done, 2'b10);
        checkOutput("t2_c4_rdata", rsp_rdata, PAT_A5);
        checkOutput("t2_c4_err", rsp_err, 0);
        nextCycle();
        checkOutput("t2_idle_busy", busy, 0);

        // 3: both requesters read continuously; grants must alternate
        prevRead = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b11, 2'b00, 32'd0, 32'd1, '0, '0, '0, '0);
            #1;
            checkOutput($sformatf("t3_ready%0d", i), req_ready,
                        (i % 2 == 0) ? 2'b01 : 2'b10);
            for (int c = 1; c <= 5; c++) begin
                nextCycle();
                checkOutput($sformatf("t3_b2b%0d_%0d", i, c), mem_read & prevRead, 0);
                prevRead = mem_read;
                if (c == 1) checkOutput($sformatf("t3_busy_ready%0d", i), req_ready, 0);
                if (c == 4) begin
                    checkOutput($sformatf("t3_done%0d", i), rsp_done,
                                (i % 2 == 0) ? 2'b01 : 2'b10);
                    checkOutput($sformatf("t3_rdata%0d", i), rsp_rdata,
                                (i % 2 == 0) ? RAM0 : RAM1);
                end
            end
        end
        applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, '0, '0);

        // 4: single-byte write to zero-filled line 2
        applyStimulus(2'b01, 2'b01, 32'd2, '0, 32'h0000_0001, '0, PAT_FF, '0);
        #1;
        checkOutput("t4_ready", req_ready, 2'b01);
        nextCycle();
        applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
        nextCycle();
        checkOutput("t4_c2_be", mem_be, 32'h0000_0001);
        nextCycle();
        checkOutput("t4_done", rsp_done, 2'b01);
        checkOutput("t4_ram2", ram[2], 256'hFF);
        checkOutput("t4_rdata_kept", rsp_rdata, RAM1);
        checkOutput("t4_err", rsp_err, 0);
        nextCycle();

        // 5: read with mem_valid suppressed hits the watchdog
        forceInvalid = 1'b1;
        applyStimulus(2'b01, 2'b00, 32'd1, '0, '0, '0, '0, '0);
        #1;
        checkOutput("t5_ready", req_ready, 2'b01);
        for (int c = 1; c <= 10; c++) begin
            nextCycle();
            if (c == 1) applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
            if (c == 9) begin
                checkOutput("t5_c9_done", rsp_done, 0);
                checkOutput("t5_c9_busy", busy, 1);
            end
            if (c == 10) begin
                checkOutput("t5_done", rsp_done, 2'b01);
                checkOutput("t5_err", rsp_err, 1);
                checkOutput("t5_rdata", rsp_rdata, 0);
            end
        end
        forceInvalid = 1'b0;
        nextCycle();
        checkOutput("t5_idle_err", rsp_err, 0);

        // 6: reset asserted during WR_SETUP aborts the write
        applyStimulus(2'b10, 2'b10, '0, 32'd4, '0, 32'hFFFF_FFFF, '0, PAT_5A);
        #1;
        checkOutput("t6_ready", req_ready, 2'b10);
        nextCycle();
        checkOutput("t6_setup_addr", mem_a, 4);
        checkOutput("t6_setup_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_addr", mem_a, 0);
        checkOutput("t6_rst_write", mem_write, 0);
        checkOutput("t6_rst_busy", busy, 0);
        applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            nextCycle();
            checkOutput($sformatf("t6_nodone%0d", c), rsp_done, 0);
            checkOutput($sformatf("t6_nowrite%0d", c), mem_write, 0);
        end
        checkOutput("t6_ram4", ram[4], 0);
        applyStimulus(2'b11, 2'b00, 32'd0, 32'd1, '0, '0, '0, '0);
        #1;
        checkOutput("t6_first_grant", req_ready, 2'b01);
        applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
        nextCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
